// File: rtl/prbs_checker.sv
// prbs_checker: receive-side BIST checker for the 4-bit LFSR pattern generator.
// Locks onto the incoming LFSR word stream, then flags and counts every deviating word.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  in_data carries a valid LFSR word this cycle
//   in_data   received LFSR state word (WIDTH bits)
//   err_clr   synchronous clear of err_cnt
//   locked    checker is synchronised to the sequence (registered)
//   err       one-cycle pulse, previous valid word mismatched while locked
//   err_cnt   saturating count of mismatches seen while locked (CNT_W bits)
module prbs_checker #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1001,
    parameter int               LOCK_CNT   = 3,
    parameter int               UNLOCK_CNT = 4,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [MW-1:0]    LOCK_V   = MW'(LOCK_CNT);
    localparam logic [UW-1:0]    UNLOCK_V = UW'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Same next-state function as the generator.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] expected_q;
    logic             have_seed_q;
    logic [MW-1:0]    match_q;
    logic [UW-1:0]    miss_q;
    logic             locked_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] exp_run_d;
    logic [WIDTH-1:0] exp_seed_d;
    logic             hit;
    logic             mism;
    logic [MW-1:0]    match_inc;
    logic [UW-1:0]    miss_inc;
    logic             count_en;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] err_cnt_d;

    always_comb begin
        exp_run_d  = lfsr_next(expected_q);
        exp_seed_d = lfsr_next(in_data);
        mism       = (in_data != expected_q);
        hit        = have_seed_q && !mism;
        match_inc  = match_q + MW'(1);
        miss_inc   = miss_q + UW'(1);
        count_en   = in_valid && (state_q == ST_LOCKED) && mism;
        // Clear applies first so a same-cycle mismatch lands on 1.
        cnt_base   = err_clr ? '0 : cnt_q;
        err_cnt_d  = cnt_base;
        if (count_en && (cnt_base != CNT_MAX)) begin
            err_cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            expected_q  <= '0;
            have_seed_q <= 1'b0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= err_cnt_d;
            err_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (in_valid) begin
                        expected_q  <= exp_seed_d;
                        // An all-zero word would lock the LFSR at zero.
                        have_seed_q <= |in_data;
                        if (hit) begin
                            if (match_inc == LOCK_V) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= '0;
                                miss_q   <= '0;
                            end else begin
                                match_q <= match_inc;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (in_valid) begin
                        // Free-run: a single bad word costs one error only.
                        expected_q <= exp_run_d;
                        if (!mism) begin
                            miss_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                            if (miss_inc == UNLOCK_V) begin
                                state_q     <= ST_SEARCH;
                                locked_q    <= 1'b0;
                                have_seed_q <= 1'b0;
                                match_q     <= '0;
                                miss_q      <= '0;
                            end else begin
                                miss_q <= miss_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= ST_SEARCH;
                    locked_q    <= 1'b0;
                    have_seed_q <= 1'b0;
                    match_q     <= '0;
                    miss_q      <= '0;
                end
            endcase
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: vector table, directed saturation sequence and random
// stimulus against a sequence-table reference model, on CNT_W=8 and CNT_W=2.
module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       err_clr = 1'b0;
    logic       locked8, err8;
    logic [7:0] cnt8;
    logic       locked2, err2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    prbs_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(3),
                   .UNLOCK_CNT(4), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .err_clr(err_clr), .locked(locked8), .err(err8), .err_cnt(cnt8)
    );

    prbs_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(3),
                   .UNLOCK_CNT(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .err_clr(err_clr), .locked(locked2), .err(err2), .err_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the full m-sequence as a table, position-based tracking.
    int seq [15];
    bit m_locked, m_err, m_seeded;
    int m_c8, m_c2, m_run, m_bad, m_pos, m_last;

    function automatic int seq_idx(input int w);
        for (int i = 0; i < 15; i++) if (seq[i] == w) return i;
        return -1;
    endfunction

    function automatic int succ(input int w);
        int i;
        i = seq_idx(w);
        return (i < 0) ? -1 : seq[(i + 1) % 15];
    endfunction

    task automatic model_step(input bit r, input bit v, input int d, input bit c);
        bit hit;
        int e;
        if (r) begin
            m_locked = 0; m_err = 0; m_seeded = 0;
            m_c8 = 0; m_c2 = 0; m_run = 0; m_bad = 0; m_pos = 0; m_last = 0;
            return;
        end
        m_err = 0;
        if (c) begin m_c8 = 0; m_c2 = 0; end
        if (!v) return;
        if (!m_locked) begin
            hit = m_seeded && (d == succ(m_last));
            m_last = d;
            m_seeded = (d != 0);
            if (hit) begin
                m_run++;
                if (m_run == 3) begin
                    m_locked = 1; m_run = 0; m_bad = 0;
                    m_pos = (seq_idx(d) + 1) % 15;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            e = seq[m_pos];
            m_pos = (m_pos + 1) % 15;
            if (d == e) begin
                m_bad = 0;
            end else begin
                m_err = 1;
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
                m_bad++;
                if (m_bad == 4) begin
                    m_locked = 0; m_seeded = 0; m_run = 0; m_bad = 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit c);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d[3:0]; err_clr = c;
        @(posedge clk);
        #1;
        model_step(r, v, d, c);
        chk("model locked8", int'(locked8), int'(m_locked));
        chk("model err8", int'(err8), int'(m_err));
        chk("model cnt8", int'(cnt8), m_c8);
        chk("model locked2", int'(locked2), int'(m_locked));
        chk("model err2", int'(err2), int'(m_err));
        chk("model cnt2", int'(cnt2), m_c2);
    endtask

    typedef struct {
        bit r; bit v; int d; bit c;
        bit l; bit e; int n;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input bit r, input bit v, input int d, input bit c,
                       input bit l, input bit e, input int n);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.c = c; x.l = l; x.e = e; x.n = n;
        tbl.push_back(x);
    endtask

    initial begin
        int s, p, gp, d;
        bit r, v, c;
        int roll;
        s = 1;
        for (int i = 0; i < 15; i++) begin
            seq[i] = s;
            s = ((s << 1) & 15) | ($countones(s & 9) & 1);
        end

        // Lock acquisition
        add(1,0,0,0, 0,0,0);
        add(1,0,0,0, 0,0,0);
        add(0,1,4'b0001,0, 0,0,0);
        add(0,1,4'b0011,0, 0,0,0);
        add(0,1,4'b0111,0, 0,0,0);
        add(0,1,4'b1111,0, 1,0,0);
        // Single error injection
        add(0,1,4'b0000,0, 1,1,1);
        add(0,1,4'b1101,0, 1,0,1);
        add(0,1,4'b1010,0, 1,0,1);
        add(0,1,4'b0101,0, 1,0,1);
        // Loss of lock
        add(0,1,4'b1111,0, 1,1,2);
        add(0,1,4'b1111,0, 1,1,3);
        add(0,1,4'b1111,0, 1,1,4);
        add(0,1,4'b1111,0, 0,1,5);
        // Relock
        add(0,1,4'b0010,0, 0,0,5);
        add(0,1,4'b0100,0, 0,0,5);
        add(0,1,4'b1000,0, 0,0,5);
        add(0,1,4'b0001,0, 1,0,5);
        // Clear alone
        add(0,1,4'b0011,1, 1,0,0);
        // Two errors, then reset mid-word
        add(0,1,4'b0000,0, 1,1,1);
        add(0,1,4'b1111,0, 1,0,1);
        add(0,1,4'b0000,0, 1,1,2);
        add(1,1,4'b1101,0, 0,0,0);
        add(0,1,4'b1110,0, 0,0,0);
        add(0,1,4'b1101,0, 0,0,0);
        add(0,1,4'b1010,0, 0,0,0);
        add(0,1,4'b0101,0, 1,0,0);
        // Zero words never seed; gaps change nothing
        add(1,0,0,0, 0,0,0);
        add(0,1,4'b0000,0, 0,0,0);
        add(0,1,4'b0000,0, 0,0,0);
        add(0,1,4'b0000,0, 0,0,0);
        add(0,1,4'b0000,0, 0,0,0);
        add(0,0,4'b1010,0, 0,0,0);
        add(0,0,4'b1010,0, 0,0,0);
        add(0,1,4'b0001,0, 0,0,0);
        add(0,0,4'b1111,0, 0,0,0);
        add(0,0,4'b1111,0, 0,0,0);
        add(0,1,4'b0011,0, 0,0,0);
        add(0,0,4'b0000,0, 0,0,0);
        add(0,0,4'b0000,0, 0,0,0);
        add(0,1,4'b0111,0, 0,0,0);
        add(0,0,4'b0110,0, 0,0,0);
        add(0,0,4'b0110,0, 0,0,0);
        add(0,1,4'b1111,0, 1,0,0);
        add(0,0,4'b0000,0, 1,0,0);
        // err is a single pulse; expected does not advance over a gap
        add(0,1,4'b0000,0, 1,1,1);
        add(0,0,4'b1110,0, 1,0,1);
        add(0,1,4'b1101,0, 1,0,1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d locked", i), int'(locked8), int'(tbl[i].l));
            chk($sformatf("vec%0d err", i), int'(err8), int'(tbl[i].e));
            chk($sformatf("vec%0d err_cnt", i), int'(cnt8), tbl[i].n);
        end

        // Saturation on the 2-bit counter, then clear with a counted error
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, seq[i], 0);
        chk("sat locked", int'(locked2), 1);
        p = 4;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0);
            chk("sat err pulse", int'(err2), 1);
            p++;
            step(0, 1, seq[p % 15], 0);
            chk("sat no err", int'(err2), 0);
            p++;
        end
        chk("sat cnt2", int'(cnt2), 3);
        chk("sat cnt8", int'(cnt8), 5);
        chk("sat still locked", int'(locked2), 1);
        step(0, 1, 0, 1);
        chk("clr+err cnt2", int'(cnt2), 1);
        chk("clr+err cnt8", int'(cnt8), 1);
        chk("clr+err err", int'(err2), 1);

        // Random traffic from a tracked generator with corruption and jumps
        step(1, 0, 0, 0);
        gp = $urandom_range(0, 14);
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            d = $urandom_range(0, 15);
            if (v) begin
                roll = $urandom_range(0, 29);
                if (roll == 0) begin
                    d = 0;
                end else if (roll <= 2) begin
                    d = $urandom_range(0, 15);
                end else if (roll == 3) begin
                    gp = $urandom_range(0, 14);
                    d = seq[gp];
                    gp = (gp + 1) % 15;
                end else if (roll == 4) begin
                    d = seq[gp] ^ 6;
                end else begin
                    d = seq[gp];
                    gp = (gp + 1) % 15;
                end
            end
            step(r, v, d, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Downstream consumer of the 4-bit LFSR pattern generator.
- Samples each parallel LFSR state word and predicts the next word using the same polynomial.
- Self-synchronises (locks) to the incoming sequence, then flags and counts every word that deviates from the prediction.
- Used as the receive-side BIST checker on links driven by the LFSR.

Parameters:
- WIDTH, 4, LFSR state width in bits.
- TAPS, 4'b1001, feedback tap mask. With TAPS=4'b1001 the generator is x^4+x^3+1 (period 15).
- LOCK_CNT, 3, consecutive correct predictions needed to enter LOCKED (≥1).
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that force a return to SEARCH (≥1).
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is a valid LFSR word this cycle.
- in_data  input  WIDTH  received LFSR state word.
- err_clr  input  1  synchronous clear of err_cnt.
- locked  output  1  checker is synchronised to the sequence.
- err  output  1  one-cycle pulse: previous valid word mismatched while LOCKED.
- err_cnt  output  CNT_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Next-state function f(s): {s[WIDTH-2:0], ^(s & TAPS)} (shift left, XOR feedback into bit 0), identical to the generator.
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state=SEARCH, locked=0, err=0, err_cnt=0.
  - expected=0, have_seed=0, match_cnt=0, miss_cnt=0.
  - rst overrides every other input.
- in_valid=0: no state, counter or expected update; err=0 next cycle.
- SEARCH, on in_valid:
  - hit = have_seed && in_data==expected.
  - hit: if match_cnt+1==LOCK_CNT then go to LOCKED, locked=1 next cycle, match_cnt=0, miss_cnt=0. Otherwise match_cnt++.
  - no hit: match_cnt=0.
  - Always: expected<=f(in_data), have_seed<=(in_data!=0). An all-zero word is never a valid seed.
  - err is never asserted and err_cnt never changes in SEARCH.
- LOCKED, on in_valid:
  - expected<=f(expected). The checker free-runs and never reseeds from data, so a single corrupted word produces exactly one error.
  - Match: miss_cnt=0, err=0.
  - Mismatch (including all-zero word): err=1 next cycle, err_cnt increments (saturates at 2^CNT_W-1), miss_cnt++.
  - If miss_cnt+1==UNLOCK_CNT: go to SEARCH, locked=0 next cycle, have_seed=0, match_cnt=0, miss_cnt=0.
- Latency: err and locked update on the edge after the sampled word, i.e. 1 cycle.
- err_clr:
  - Sets err_cnt=0 next cycle.
  - If a mismatch is counted in the same cycle, err_cnt=1 (clear then count).
  - Does not affect locked, err or the FSM.
- The FSM has exactly two states; any illegal encoding recovers to SEARCH.

Test Plan:
- Lock acquisition:
  - Stimulus: reset 2 cycles, then valid words 0001,0011,0111,1111 back-to-back.
  - Response: locked=0 through the 3rd word, locked=1 the cycle after 1111 is sampled, err_cnt=0.
- Single error injection:
  - Stimulus: after lock, send 0000 in place of 1110, then continue 1101,1010,0101.
  - Response: exactly one err pulse, err_cnt=1, locked stays 1, no further errors.
- Loss of lock:
  - Stimulus: after lock, send four words 1111 where 1110,1101,1010,0101 are expected.
  - Response: err pulses on 4 consecutive cycles, err_cnt=4, locked=0 after the 4th.
  - Then resend a correct run of 4 words: relock.
- Valid gaps and all-zero seed:
  - Stimulus: in SEARCH, send 0000 then 0001,0011,0111,1111 with in_valid low 2 cycles between each word.
  - Response: the zero word does not seed, lock after 1111, and the gaps cause no state change.
- Saturation and clear:
  - Stimulus: CNT_W=2, lock, inject 5 isolated errors.
  - Response: err_cnt=3 (saturated).
  - Then assert err_clr together with a 6th error: err_cnt=1.
- Reset mid-operation:
  - Stimulus: while locked with err_cnt=2, assert rst for 1 cycle during a valid word.
  - Response: next cycle locked=0, err=0, err_cnt=0; relock requires the full LOCK_CNT sequence.
